at_cmd_responder: RTL

//  Device-side end of the BLE AT-command link. Pulls bytes from the UART RX FIFO and assembles CR-LF terminated lines.

---
 rtl/at_resp_types_pkg.sv | 40 ++++
 rtl/at_line_buf.sv | 47 ++++
 rtl/at_cmd_responder.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/at_resp_types_pkg.sv
// at_resp_types_pkg
//   Shared types and constants for the AT-command responder: FSM state
//   encoding, line terminator characters, the command-prefix characters and
//   the two canned response strings ("OK\r\n" and "ERROR\r\n").
//   The ECHO state is only reachable when AT_ECHO_EN is defined.
package at_resp_types_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ECHO,
        CHECK,
        RESPOND
    } at_resp_state_t;

    localparam logic [7:0] CHAR_CR   = 8'h0D;
    localparam logic [7:0] CHAR_LF   = 8'h0A;
    localparam logic [7:0] CHAR_A    = 8'h41;
    localparam logic [7:0] CHAR_T    = 8'h54;
    localparam logic [7:0] CHAR_PLUS = 8'h2B;

    localparam int unsigned RESP_OK_LEN  = 4;
    localparam int unsigned RESP_ERR_LEN = 7;

    localparam logic [7:0] RESP_OK [RESP_OK_LEN] = '{8'h4F, 8'h4B, CHAR_CR, CHAR_LF};
    localparam logic [7:0] RESP_ERR [RESP_ERR_LEN] =
        '{8'h45, 8'h52, 8'h52, 8'h4F, 8'h52, CHAR_CR, CHAR_LF};

    // Byte idx of the selected response string.
    function automatic logic [7:0] resp_char(input logic ok, input logic [2:0] idx);
        if (ok) return RESP_OK[idx[1:0]];
        else    return RESP_ERR[idx];
    endfunction

    // Index of the final byte of the selected response string.
    function automatic logic [2:0] resp_last(input logic ok);
        return ok ? 3'(RESP_OK_LEN - 1) : 3'(RESP_ERR_LEN - 1);
    endfunction

endpackage

// File: rtl/at_line_buf.sv
// at_line_buf
//   Line storage for the AT-command responder: DEPTH x 8 bit array with a
//   write port driven by the responder FSM and a registered read port for
//   the command decoder.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset (read register only)
//   wr_en        write strobe
//   wr_addr      write index
//   wr_data      write byte
//   rd_addr      read index from the decoder
//   rd_data      registered read data, 1-cycle latency; 8'h00 when out of range
module at_line_buf
    import at_resp_types_pkg::*;
#(
    parameter  int unsigned DEPTH = 32,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // A write aimed at the entry the decoder is currently addressing is
    // suppressed so the decoder never sees a byte change under it.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr != rd_addr)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (32'(rd_addr) < DEPTH) begin
            rd_data <= mem[rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: rtl/at_cmd_responder.sv
// at_cmd_responder
//   Device-side end of the BLE AT-command link. Reads bytes from the UART RX
//   FIFO, assembles CR-LF terminated lines, validates them as AT commands and
//   answers "OK\r\n" or "ERROR\r\n" through the UART TX FIFO. Accepted lines
//   are exposed to the command decoder via cmd_valid/cmd_len and a line-buffer
//   read port.
//   Optional feature macro: AT_ECHO_EN -- echo every received byte to TX
//   before processing it.
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   rx_valid     RX FIFO not empty
//   get_rx_byte  RX FIFO read strobe (1-cycle pulse)
//   rx_ready     rx_byte valid, answers get_rx_byte
//   rx_byte      byte from RX FIFO
//   tx_full      TX FIFO full
//   byte_ready   TX FIFO write strobe (1-cycle pulse)
//   tx_byte      byte to TX FIFO
//   cmd_valid    1-cycle pulse: valid line accepted
//   cmd_len      stored length of the accepted line
//   cmd_rd_addr  line-buffer read address
//   cmd_rd_data  line-buffer read data, 1-cycle latency
//   timeout      1-cycle pulse: partial line discarded after RX silence
module at_cmd_responder
    import at_resp_types_pkg::*;
#(
    parameter  int unsigned MAX_CMD_LEN      = 32,
    parameter  logic [23:0] IDLE_TIMEOUT_CYC = 24'd20000,
    localparam int unsigned W                = $clog2(MAX_CMD_LEN + 1),
    localparam int unsigned A                = $clog2(MAX_CMD_LEN)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx_valid,
    output logic         get_rx_byte,
    input  logic         rx_ready,
    input  logic [7:0]   rx_byte,
    input  logic         tx_full,
    output logic         byte_ready,
    output logic [7:0]   tx_byte,
    output logic         cmd_valid,
    output logic [W-1:0] cmd_len,
    input  logic [A-1:0] cmd_rd_addr,
    output logic [7:0]   cmd_rd_data,
    output logic         timeout
);

    at_resp_state_t state, state_n, after_fetch;
    logic [W-1:0]   count, count_n;
    logic           pending_cr, pend_n;
    logic           overflow, ovf_n;
    logic [23:0]    timer, timer_n;
    logic           resp_ok, resp_ok_n;
    logic [2:0]     resp_idx, resp_idx_n;
    logic [7:0]     head [3];
    logic [7:0]     head_n [3];
    logic [W-1:0]   cmd_len_n;
    logic           get_n, cmd_valid_n, timeout_n;
    logic           counting, take;
    logic           wr_en;
    logic [A-1:0]   wr_addr;
    logic [7:0]     wr_data;
`ifdef AT_ECHO_EN
    logic [7:0]     echo_byte, echo_byte_n;
    at_resp_state_t echo_next, echo_next_n;
`endif

    at_line_buf #(
        .DEPTH (MAX_CMD_LEN)
    ) u_line_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (cmd_rd_addr),
        .rd_data (cmd_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            pending_cr  <= 1'b0;
            overflow    <= 1'b0;
            timer       <= '0;
            resp_ok     <= 1'b0;
            resp_idx    <= '0;
            head        <= '{default: '0};
            cmd_len     <= '0;
            get_rx_byte <= 1'b0;
            cmd_valid   <= 1'b0;
            timeout     <= 1'b0;
`ifdef AT_ECHO_EN
            echo_byte   <= '0;
            echo_next   <= IDLE;
`endif
        end else begin
            state       <= state_n;
            count       <= count_n;
            pending_cr  <= pend_n;
            overflow    <= ovf_n;
            timer       <= timer_n;
            resp_ok     <= resp_ok_n;
            resp_idx    <= resp_idx_n;
            head        <= head_n;
            cmd_len     <= cmd_len_n;
            get_rx_byte <= get_n;
            cmd_valid   <= cmd_valid_n;
            timeout     <= timeout_n;
`ifdef AT_ECHO_EN
            echo_byte   <= echo_byte_n;
            echo_next   <= echo_next_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        count_n     = count;
        pend_n      = pending_cr;
        ovf_n       = overflow;
        timer_n     = timer;
        resp_ok_n   = resp_ok;
        resp_idx_n  = resp_idx;
        head_n      = head;
        cmd_len_n   = cmd_len;
        get_n       = 1'b0;
        cmd_valid_n = 1'b0;
        timeout_n   = 1'b0;
        after_fetch = IDLE;
        wr_en       = 1'b0;
        wr_addr     = count[A-1:0];
        wr_data     = rx_byte;
        byte_ready  = 1'b0;
        tx_byte     = '0;
`ifdef AT_ECHO_EN
        echo_byte_n = echo_byte;
        echo_next_n = echo_next;
`endif

        // Silence timer: a byte arriving in the expiry cycle wins, so the
        // partial line is never dropped while a byte is being consumed.
        counting = ((state == IDLE) || (state == FETCH)) && ((count != '0) || pending_cr);
        take     = (state == FETCH) && rx_ready;
        if (!counting || take) begin
            timer_n = '0;
        end else if (timer == IDLE_TIMEOUT_CYC - 24'd1) begin
            timer_n   = '0;
            timeout_n = 1'b1;
            count_n   = '0;
            pend_n    = 1'b0;
            ovf_n     = 1'b0;
        end else begin
            timer_n = timer + 24'd1;
        end

        case (state)
            IDLE: begin
                if (rx_valid) begin
                    get_n   = 1'b1;
                    state_n = FETCH;
                end
            end

            FETCH: begin
                if (rx_ready) begin
                    if (rx_byte == CHAR_CR) begin
                        pend_n      = 1'b1;
                        after_fetch = IDLE;
                    end else if ((rx_byte == CHAR_LF) && pending_cr) begin
                        after_fetch = CHECK;
                    end else begin
                        pend_n = 1'b0;
                        if (count == W'(MAX_CMD_LEN)) begin
                            ovf_n = 1'b1;
                        end else begin
                            wr_en   = 1'b1;
                            count_n = count + W'(1);
                            if (count < W'(3)) begin
                                head_n[count[1:0]] = rx_byte;
                            end
                        end
                        after_fetch = IDLE;
                    end
`ifdef AT_ECHO_EN
                    echo_byte_n = rx_byte;
                    echo_next_n = after_fetch;
                    state_n     = ECHO;
`else
                    state_n     = after_fetch;
`endif
                end
            end

`ifdef AT_ECHO_EN
            ECHO: begin
                if (!tx_full) begin
                    byte_ready = 1'b1;
                    tx_byte    = echo_byte;
                    state_n    = echo_next;
                end
            end
`endif

            CHECK: begin
                pend_n = 1'b0;
                if ((count == '0) && !overflow) begin
                    state_n = IDLE;
                end else begin
                    if (!overflow && (count >= W'(2)) &&
                        (head[0] == CHAR_A) && (head[1] == CHAR_T) &&
                        ((count == W'(2)) || (head[2] == CHAR_PLUS))) begin
                        cmd_valid_n = 1'b1;
                        cmd_len_n   = count;
                        resp_ok_n   = 1'b1;
                    end else begin
                        resp_ok_n   = 1'b0;
                    end
                    resp_idx_n = '0;
                    state_n    = RESPOND;
                end
            end

            RESPOND: begin
                if (!tx_full) begin
                    byte_ready = 1'b1;
                    tx_byte    = resp_char(resp_ok, resp_idx);
                    if (resp_idx == resp_last(resp_ok)) begin
                        count_n = '0;
                        ovf_n   = 1'b0;
                        pend_n  = 1'b0;
                        state_n = IDLE;
                    end else begin
                        resp_idx_n = resp_idx + 3'd1;
                    end
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
